pio_bus_arbiter: RTL and testbench

Shares the 8-bit PIO CPU-style bus (addr, data_tx, data_rx, cs_n, oe_n, we_n) between two independent requesters, for example a CPU bridge and a pattern/DMA engine. It does round-robin arbitration and sequences each granted access into a setup/strobe/hold cycle with active-low strobes. Because the PIO derives its register clocks from the strobes, each strobe is held low across at least one rising clk edge. The block sits directly between the requesters and the PIO instance.

---
 rtl/pio_bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_pio_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// pio_bus_arbiter
//
// Shares one 8-bit PIO CPU-style bus between two independent requesters.
// Requests are arbitrated round-robin. Each granted access is sequenced
// as SETUP (1 cycle), STROBE (STROBE_CYCLES cycles) and HOLD (1 cycle),
// followed by at least one IDLE cycle with cs_n high. Strobes are active
// low and stay low across at least one rising clk edge, because the PIO
// derives its register clocks from them.
//
// Ports:
//   clk, reset             system clock, synchronous active-low reset
//   rN_req                 level request from requester N (N = 0, 1)
//   rN_we                  1 = write, 0 = read
//   rN_addr, rN_wdata      access address / write data, sampled at grant
//   rN_ack                 one-cycle completion pulse (HOLD cycle)
//   rN_rdata               last read result for requester N
//   addr, data_tx          PIO address / write data (always driven)
//   data_rx                PIO read data
//   cs_n, oe_n, we_n       PIO chip select, read strobe, write strobe
//   busy                   high whenever the FSM is not in IDLE
//   grant_id               requester currently or most recently served
//
// Handshake: a requester holds rN_req high with stable fields until it is
// granted; fields are captured at the grant edge. rN_ack pulses for one
// cycle when the access completes. Dropping rN_req early does not abort
// an access; rN_req still high in IDLE counts as a new request.
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module pio_bus_arbiter #(
    parameter int ADDR_W        = 2,
    parameter int DATA_W        = 8,
    parameter int STROBE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_tx,
    input  logic [DATA_W-1:0] data_rx,
    output logic              cs_n,
    output logic              oe_n,
    output logic              we_n,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // The counter counts remaining STROBE cycles after the current one.
    localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

    state_t            state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic              wr, wr_d;
    logic              pick;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_tx_d;
    logic              grant_id_d;
    logic              r0_ack_d, r1_ack_d;
    logic [DATA_W-1:0] r0_rdata_d, r1_rdata_d;

    // Next-state and next-register-value logic.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        wr_d       = wr;
        pick       = 1'b0;
        addr_d     = addr;
        data_tx_d  = data_tx;
        grant_id_d = grant_id;
        r0_ack_d   = 1'b0;
        r1_ack_d   = 1'b0;
        r0_rdata_d = r0_rdata;
        r1_rdata_d = r1_rdata;

        case (state)
            IDLE: begin
                if (r0_req || r1_req) begin
                    // Under contention serve the one not served last.
                    pick       = (r0_req && r1_req) ? ~grant_id : r1_req;
                    grant_id_d = pick;
                    wr_d       = pick ? r1_we    : r0_we;
                    addr_d     = pick ? r1_addr  : r0_addr;
                    data_tx_d  = pick ? r1_wdata : r0_wdata;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = CNT_LOAD;
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    // Last strobe edge: capture read data, ack lands in HOLD.
                    state_d = HOLD;
                    if (!wr) begin
                        if (grant_id) r1_rdata_d = data_rx;
                        else          r0_rdata_d = data_rx;
                    end
                    if (grant_id) r1_ack_d = 1'b1;
                    else          r0_ack_d = 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Bus controls are decoded from the next
    // state so they appear in the same cycle as the state they belong to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            wr       <= 1'b0;
            addr     <= '0;
            data_tx  <= '0;
            grant_id <= 1'b1;
            r0_ack   <= 1'b0;
            r1_ack   <= 1'b0;
            r0_rdata <= '0;
            r1_rdata <= '0;
            cs_n     <= 1'b1;
            oe_n     <= 1'b1;
            we_n     <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            wr       <= wr_d;
            addr     <= addr_d;
            data_tx  <= data_tx_d;
            grant_id <= grant_id_d;
            r0_ack   <= r0_ack_d;
            r1_ack   <= r1_ack_d;
            r0_rdata <= r0_rdata_d;
            r1_rdata <= r1_rdata_d;
            cs_n     <= (state_d == IDLE);
            oe_n     <= !((state_d == STROBE) && !wr_d);
            we_n     <= !((state_d == STROBE) && wr_d);
            busy     <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_pio_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pio_bus_arbiter
//
// Bench for pio_bus_arbiter. Instance dut uses STROBE_CYCLES=2, instance
// dut1 uses STROBE_CYCLES=1. Inputs change on the falling edge; outputs
// are sampled on the falling edge after each rising edge. Expected values
// are hand-computed cycle by cycle.
// ---------------------------------------------------------------------------
module tb_pio_bus_arbiter;

    logic clk;
    logic reset;
    logic [7:0] data_rx;

    // Instance with STROBE_CYCLES = 2
    logic       r0_req, r0_we, r1_req, r1_we;
    logic [1:0] r0_addr, r1_addr;
    logic [7:0] r0_wdata, r1_wdata;
    logic       r0_ack, r1_ack, cs_n, oe_n, we_n, busy, grant_id;
    logic [7:0] r0_rdata, r1_rdata, data_tx;
    logic [1:0] addr;

    // Instance with STROBE_CYCLES = 1
    logic       b_r0_req, b_r0_we, b_r1_req, b_r1_we;
    logic [1:0] b_r0_addr, b_r1_addr;
    logic [7:0] b_r0_wdata, b_r1_wdata;
    logic       b_r0_ack, b_r1_ack, b_cs_n, b_oe_n, b_we_n, b_busy, b_grant_id;
    logic [7:0] b_r0_rdata, b_r1_rdata, b_data_tx;
    logic [1:0] b_addr;

    logic [32:0] obs_a, obs_b;
    assign obs_a = {cs_n, oe_n, we_n, r0_ack, r1_ack, busy, grant_id,
                    addr, data_tx, r0_rdata, r1_rdata};
    assign obs_b = {b_cs_n, b_oe_n, b_we_n, b_r0_ack, b_r1_ack, b_busy, b_grant_id,
                    b_addr, b_data_tx, b_r0_rdata, b_r1_rdata};

    pio_bus_arbiter #(.ADDR_W(2), .DATA_W(8), .STROBE_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata),
        .addr(addr), .data_tx(data_tx), .data_rx(data_rx),
        .cs_n(cs_n), .oe_n(oe_n), .we_n(we_n), .busy(busy), .grant_id(grant_id)
    );

    pio_bus_arbiter #(.ADDR_W(2), .DATA_W(8), .STROBE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset),
        .r0_req(b_r0_req), .r0_we(b_r0_we), .r0_addr(b_r0_addr), .r0_wdata(b_r0_wdata),
        .r0_ack(b_r0_ack), .r0_rdata(b_r0_rdata),
        .r1_req(b_r1_req), .r1_we(b_r1_we), .r1_addr(b_r1_addr), .r1_wdata(b_r1_wdata),
        .r1_ack(b_r1_ack), .r1_rdata(b_r1_rdata),
        .addr(b_addr), .data_tx(b_data_tx), .data_rx(data_rx),
        .cs_n(b_cs_n), .oe_n(b_oe_n), .we_n(b_we_n), .busy(b_busy), .grant_id(b_grant_id)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [32:0] pk(input int cs, input int oe, input int we,
                                       input int a0, input int a1, input int bz,
                                       input int gid, input int ad, input int dt,
                                       input int rd0, input int rd1);
        return {cs[0], oe[0], we[0], a0[0], a1[0], bz[0], gid[0],
                ad[1:0], dt[7:0], rd0[7:0], rd1[7:0]};
    endfunction

    typedef struct {
        logic        r0q, r0w, r1q, r1w;
        logic [1:0]  r0a, r1a;
        logic [7:0]  r0d, r1d, rx;
        logic [32:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input int r0q, input int r0w, input int r0a, input int r0d,
                              input int r1q, input int r1w, input int r1a, input int r1d,
                              input int rx,
                              input int cs, input int oe, input int we, input int a0,
                              input int a1, input int bz, input int gid, input int ad,
                              input int dt, input int rd0, input int rd1);
        vec_t t;
        t.r0q = r0q[0]; t.r0w = r0w[0]; t.r0a = r0a[1:0]; t.r0d = r0d[7:0];
        t.r1q = r1q[0]; t.r1w = r1w[0]; t.r1a = r1a[1:0]; t.r1d = r1d[7:0];
        t.rx  = rx[7:0];
        t.exp = pk(cs, oe, we, a0, a1, bz, gid, ad, dt, rd0, rd1);
        vecs.push_back(t);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One access on dut1; returns cycles to ack and strobe-low cycle count.
    task automatic b_access(input int who, input int wr, input int a, input int d,
                            output int lat, output int low, output logic [7:0] dt_seen);
        lat = 0;
        low = 0;
        dt_seen = 8'h00;
        if (who == 0) begin
            b_r0_req = 1'b1; b_r0_we = wr[0]; b_r0_addr = a[1:0]; b_r0_wdata = d[7:0];
        end else begin
            b_r1_req = 1'b1; b_r1_we = wr[0]; b_r1_addr = a[1:0]; b_r1_wdata = d[7:0];
        end
        while (lat < 10) begin
            tick();
            lat++;
            if ((wr != 0 && !b_we_n) || (wr == 0 && !b_oe_n)) begin
                low++;
                dt_seen = b_data_tx;
            end
            if ((who == 0 && b_r0_ack) || (who == 1 && b_r1_ack)) break;
        end
        b_r0_req = 1'b0;
        b_r1_req = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n, low;
        logic [7:0] dts;

        reset = 1'b0; data_rx = 8'h00;
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
        b_r0_req = 0; b_r0_we = 0; b_r0_addr = 0; b_r0_wdata = 0;
        b_r1_req = 0; b_r1_we = 0; b_r1_addr = 0; b_r1_wdata = 0;

        // Write r0 a0 0x01; read r1 a1 (0x5A at last strobe edge);
        // then both held: r0 write a2 0xAA / r1 read a3, order r0 r1 r0 r1.
        //  r0q w a  d     r1q w a  d     rx      cs oe we a0 a1 bz g ad dt     rd0 rd1
        v(1,1,0,'h01, 0,0,0,'h00, 'h00,  0,1,1, 0,0, 1,0, 0,'h01, 0,'h00);
        v(1,1,0,'h01, 0,0,0,'h00, 'h00,  0,1,0, 0,0, 1,0, 0,'h01, 0,'h00);
        v(1,1,0,'h01, 0,0,0,'h00, 'h00,  0,1,0, 0,0, 1,0, 0,'h01, 0,'h00);
        v(1,1,0,'h01, 0,0,0,'h00, 'h00,  0,1,1, 1,0, 1,0, 0,'h01, 0,'h00);
        v(0,1,0,'h01, 0,0,0,'h00, 'h00,  1,1,1, 0,0, 0,0, 0,'h01, 0,'h00);
        v(0,0,0,'h00, 1,0,1,'h33, 'h00,  0,1,1, 0,0, 1,1, 1,'h33, 0,'h00);
        v(0,0,0,'h00, 1,0,1,'h33, 'h11,  0,0,1, 0,0, 1,1, 1,'h33, 0,'h00);
        v(0,0,0,'h00, 1,0,1,'h33, 'h11,  0,0,1, 0,0, 1,1, 1,'h33, 0,'h00);
        v(0,0,0,'h00, 1,0,1,'h33, 'h5A,  0,1,1, 0,1, 1,1, 1,'h33, 0,'h5A);
        v(0,0,0,'h00, 0,0,1,'h33, 'h00,  1,1,1, 0,0, 0,1, 1,'h33, 0,'h5A);
        v(1,1,2,'hAA, 1,0,3,'h55, 'hC3,  0,1,1, 0,0, 1,0, 2,'hAA, 0,'h5A);
        v(1,1,2,'hAA, 1,0,3,'h55, 'hC3,  0,1,0, 0,0, 1,0, 2,'hAA, 0,'h5A);
        v(1,1,2,'hAA, 1,0,3,'h55, 'hC3,  0,1,0, 0,0, 1,0, 2,'hAA, 0,'h5A);
        v(1,1,2,'hAA, 1,0,3,'h55, 'hC3,  0,1,1, 1,0, 1,0, 2,'hAA, 0,'h5A);
        v(1,1,2,'hAA, 1,0,3,'h55, 'hC3,  1,1,1, 0,0, 0,0, 2,'hAA, 0,'h5A);
        v(1,1,2,'hAA, 1,0,3,'h55, 'hC3,  0,1,1, 0,0, 1,1, 3,'h55, 0,'h5A);
        v(1,1,2,'hAA, 1,0,3,'h55, 'hC3,  0,0,1, 0,0, 1,1, 3,'h55, 0,'h5A);
        v(1,1,2,'hAA, 1,0,3,'h55, 'hC3,  0,0,1, 0,0, 1,1, 3,'h55, 0,'h5A);
        v(1,1,2,'hAA, 1,0,3,'h55, 'hC3,  0,1,1, 0,1, 1,1, 3,'h55, 0,'hC3);
        v(1,1,2,'hAA, 1,0,3,'h55, 'hC3,  1,1,1, 0,0, 0,1, 3,'h55, 0,'hC3);
        v(1,1,2,'hAA, 1,0,3,'h55, 'hC3,  0,1,1, 0,0, 1,0, 2,'hAA, 0,'hC3);
        v(1,1,2,'hAA, 1,0,3,'h55, 'hC3,  0,1,0, 0,0, 1,0, 2,'hAA, 0,'hC3);
        v(1,1,2,'hAA, 1,0,3,'h55, 'hC3,  0,1,0, 0,0, 1,0, 2,'hAA, 0,'hC3);
        v(1,1,2,'hAA, 1,0,3,'h55, 'hC3,  0,1,1, 1,0, 1,0, 2,'hAA, 0,'hC3);
        v(1,1,2,'hAA, 1,0,3,'h55, 'hC3,  1,1,1, 0,0, 0,0, 2,'hAA, 0,'hC3);
        v(1,1,2,'hAA, 1,0,3,'h55, 'h3C,  0,1,1, 0,0, 1,1, 3,'h55, 0,'hC3);
        v(1,1,2,'hAA, 1,0,3,'h55, 'h3C,  0,0,1, 0,0, 1,1, 3,'h55, 0,'hC3);
        v(1,1,2,'hAA, 1,0,3,'h55, 'h3C,  0,0,1, 0,0, 1,1, 3,'h55, 0,'hC3);
        v(1,1,2,'hAA, 1,0,3,'h55, 'h3C,  0,1,1, 0,1, 1,1, 3,'h55, 0,'h3C);
        v(0,1,2,'hAA, 0,0,3,'h55, 'h00,  1,1,1, 0,0, 0,1, 3,'h55, 0,'h3C);

        // Reset held three cycles
        repeat (3) tick();
        chk("reset_dut",  obs_a, pk(1,1,1, 0,0, 0,1, 0,0, 0,0));
        chk("reset_dut1", obs_b, pk(1,1,1, 0,0, 0,1, 0,0, 0,0));
        reset = 1'b1;
        tick();
        chk("idle_after_reset", obs_a, pk(1,1,1, 0,0, 0,1, 0,0, 0,0));

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            r0_req = vecs[i].r0q; r0_we = vecs[i].r0w; r0_addr = vecs[i].r0a; r0_wdata = vecs[i].r0d;
            r1_req = vecs[i].r1q; r1_we = vecs[i].r1w; r1_addr = vecs[i].r1a; r1_wdata = vecs[i].r1d;
            data_rx = vecs[i].rx;
            tick();
            chk($sformatf("vec%0d", i), obs_a, vecs[i].exp);
        end

        // Reset during STROBE of an r0 write
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 2'd1; r0_wdata = 8'h77;
        tick();
        tick();
        chk("mid_strobe", obs_a, pk(0,1,0, 0,0, 1,0, 1,'h77, 0,'h3C));
        reset = 1'b0; r0_req = 1'b0;
        tick();
        chk("reset_mid_strobe", obs_a, pk(1,1,1, 0,0, 0,1, 0,0, 0,0));
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("no_ack_after_reset%0d", i), obs_a, pk(1,1,1, 0,0, 0,1, 0,0, 0,0));
        end

        // Fresh r0 read; req dropped after SETUP, ack must still arrive
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 2'd2; r0_wdata = 8'h12; data_rx = 8'h96;
        n = 0; low = 0;
        while (n < 10) begin
            tick();
            n++;
            if (n == 1) r0_req = 1'b0;
            if (!oe_n) low++;
            if (r0_ack) break;
        end
        chk("fresh_read_latency", 33'(n), 33'(4));
        chk("fresh_read_oe_low",  33'(low), 33'(2));
        chk("fresh_read_state",   obs_a, pk(0,1,1, 1,0, 1,0, 2,'h12, 'h96,0));
        tick();
        chk("fresh_read_done",    obs_a, pk(1,1,1, 0,0, 0,0, 2,'h12, 'h96,0));

        // STROBE_CYCLES = 1: read then write on dut1
        data_rx = 8'hE1;
        b_access(0, 0, 3, 'h00, n, low, dts);
        chk("sc1_read_latency", 33'(n), 33'(3));
        chk("sc1_read_oe_low",  33'(low), 33'(1));
        chk("sc1_read_state",   obs_b, pk(0,1,1, 1,0, 1,0, 3,'h00, 'hE1,0));
        tick();
        data_rx = 8'h00;
        b_access(1, 1, 1, 'h5C, n, low, dts);
        chk("sc1_write_latency", 33'(n), 33'(3));
        chk("sc1_write_we_low",  33'(low), 33'(1));
        chk("sc1_write_data",    33'(dts), 33'(8'h5C));
        chk("sc1_write_state",   obs_b, pk(0,1,1, 0,1, 1,1, 1,'h5C, 'hE1,0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
